// File: rtl/dino_pkg.sv
// Shared Dino Run types and defaults: game state encoding, timing defaults
// and RGB565 key colours used by the drawing logic.
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } game_state_t;

    localparam int TICK_DIV_DEF       = 2_000_000;
    localparam int ANIM_DIV_DEF       = 8;
    localparam int PASS_PER_LEVEL_DEF = 12;
    localparam int MAX_SPEED_DEF      = 8;
    localparam int HIT_FRAMES_DEF     = 30;

    localparam logic [15:0] RGB_SKY    = 16'hFFFF;
    localparam logic [15:0] RGB_GROUND = 16'h8410;
    localparam logic [15:0] RGB_SPRITE = 16'h4208;
    localparam logic [15:0] RGB_KEY    = 16'hF81F;

endpackage

// File: rtl/dino_score_bcd.sv
// Four-digit BCD score counter: increments by one, clears, and holds at 9999.
module dino_score_bcd (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        clr,
    output logic [15:0] score
);

    logic [15:0] nxt;
    logic        carry;

    // Ripple a +1 through the digits, wrapping each 9 to 0.
    always_comb begin
        nxt   = score;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (score[4*i +: 4] == 4'd9) begin
                    nxt[4*i +: 4] = 4'd0;
                end else begin
                    nxt[4*i +: 4] = score[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            score <= 16'h0000;
        end else if (inc && score != 16'h9999) begin
            score <= nxt;
        end
    end

endmodule

// File: rtl/dino_game_sequencer.sv
// Dino Run game-state controller: IDLE/RUN/HIT/OVER sequencing, motion and
// animation ticks, obstacle reload, speed ramp and BCD score.
module dino_game_sequencer
    import dino_pkg::*;
#(
    parameter int TICK_DIV       = TICK_DIV_DEF,
    parameter int ANIM_DIV       = ANIM_DIV_DEF,
    parameter int PASS_PER_LEVEL = PASS_PER_LEVEL_DEF,
    parameter int MAX_SPEED      = MAX_SPEED_DEF,
    parameter int HIT_FRAMES     = HIT_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        collision,
    input  logic        wrap_event,
    input  logic        frame_start,
    output logic [1:0]  game_state,
    output logic        motion_tick,
    output logic        anim_tick,
    output logic        reload_obs,
    output logic [10:0] obstacle_speed,
    output logic [15:0] score_bcd,
    output logic        show_replay
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ANIM_LAST  = AW'(ANIM_DIV - 1);
    localparam logic [4:0]    PASS_LAST  = 5'(PASS_PER_LEVEL - 1);
    localparam logic [5:0]    HIT_LAST   = 6'(HIT_FRAMES - 1);
    localparam logic [10:0]   SPEED_MAX  = 11'(MAX_SPEED);

    game_state_t   state;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_nxt;
    logic [AW-1:0] anim_cnt;
    logic [4:0]    pass_cnt;
    logic [5:0]    hit_cnt;
    logic          btn_armed;
    logic          start_btn_q;
    logic          start_rise;
    logic          score_inc;
    logic          score_clr;

    assign game_state = state;
    assign start_rise = start_btn & ~start_btn_q & btn_armed;
    assign tick_nxt   = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);

    // A wrap in the same cycle as a collision is never scored.
    assign score_inc = (state == RUN) & ~collision & wrap_event;
    assign score_clr = ((state == IDLE) | (state == OVER)) & start_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            anim_cnt       <= '0;
            pass_cnt       <= '0;
            hit_cnt        <= '0;
            obstacle_speed <= 11'd1;
            motion_tick    <= 1'b0;
            anim_tick      <= 1'b0;
            reload_obs     <= 1'b0;
            show_replay    <= 1'b0;
            btn_armed      <= 1'b0;
            start_btn_q    <= 1'b1;
        end else begin
            motion_tick <= 1'b0;
            anim_tick   <= 1'b0;
            reload_obs  <= 1'b0;
            start_btn_q <= start_btn;
            if (!start_btn) begin
                btn_armed <= 1'b1;
            end
            unique case (state)
                IDLE, OVER: begin
                    if (start_rise) begin
                        state          <= RUN;
                        reload_obs     <= 1'b1;
                        show_replay    <= 1'b0;
                        tick_cnt       <= '0;
                        pass_cnt       <= '0;
                        obstacle_speed <= 11'd1;
                    end
                end
                RUN: begin
                    if (collision) begin
                        state    <= HIT;
                        tick_cnt <= '0;
                    end else begin
                        tick_cnt <= tick_nxt;
                        if (tick_nxt == TICK_LAST) begin
                            motion_tick <= 1'b1;
                            anim_tick   <= (anim_cnt == ANIM_LAST);
                            anim_cnt    <= (anim_cnt == ANIM_LAST) ? '0 : anim_cnt + AW'(1);
                        end
                        if (wrap_event) begin
                            if (pass_cnt == PASS_LAST) begin
                                pass_cnt <= '0;
                                if (obstacle_speed < SPEED_MAX) begin
                                    obstacle_speed <= obstacle_speed + 11'd1;
                                end
                            end else begin
                                pass_cnt <= pass_cnt + 5'd1;
                            end
                        end
                    end
                end
                HIT: begin
                    if (frame_start) begin
                        if (hit_cnt == HIT_LAST) begin
                            state       <= OVER;
                            hit_cnt     <= '0;
                            show_replay <= 1'b1;
                            // Force a fresh press after game over.
                            btn_armed   <= 1'b0;
                        end else begin
                            hit_cnt <= hit_cnt + 6'd1;
                        end
                    end
                end
            endcase
        end
    end

    dino_score_bcd u_score (
        .clk   (clk),
        .reset (reset),
        .inc   (score_inc),
        .clr   (score_clr),
        .score (score_bcd)
    );

endmodule

// File: tb/tb_dino_game_sequencer.sv
// Self-checking bench for dino_game_sequencer: vector table, hand-written
// corner sequences and a randomized run against a game-rule model.
module tb_dino_game_sequencer;

    localparam int TD  = 4;
    localparam int AD  = 2;
    localparam int PPL = 3;
    localparam int MS  = 3;
    localparam int HF  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_btn;
    logic        collision;
    logic        wrap_event;
    logic        frame_start;
    logic [1:0]  game_state;
    logic        motion_tick;
    logic        anim_tick;
    logic        reload_obs;
    logic [10:0] obstacle_speed;
    logic [15:0] score_bcd;
    logic        show_replay;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dino_game_sequencer #(
        .TICK_DIV       (TD),
        .ANIM_DIV       (AD),
        .PASS_PER_LEVEL (PPL),
        .MAX_SPEED      (MS),
        .HIT_FRAMES     (HF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_btn      (start_btn),
        .collision      (collision),
        .wrap_event     (wrap_event),
        .frame_start    (frame_start),
        .game_state     (game_state),
        .motion_tick    (motion_tick),
        .anim_tick      (anim_tick),
        .reload_obs     (reload_obs),
        .obstacle_speed (obstacle_speed),
        .score_bcd      (score_bcd),
        .show_replay    (show_replay)
    );

    // Game-rule model: state as 0..3, progress as plain counts.
    int m_state   = 0;
    bit m_armed   = 0;
    bit m_prev    = 1;
    bit m_motion  = 0;
    bit m_anim    = 0;
    bit m_reload  = 0;
    int run_cyc   = 0;
    int motions   = 0;
    int wraps     = 0;
    int hits      = 0;

    function automatic logic [15:0] to_bcd(int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic int exp_speed(int n);
        int s;
        s = 1 + n / PPL;
        return (s > MS) ? MS : s;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit b, input bit c, input bit w, input bit f);
        bit rise;
        bit enter_over;
        rise       = b && !m_prev && m_armed;
        enter_over = 0;
        m_motion   = 0;
        m_anim     = 0;
        m_reload   = 0;
        if (r) begin
            m_state = 0;
            m_armed = 0;
            m_prev  = 1;
            run_cyc = 0;
            motions = 0;
            wraps   = 0;
            hits    = 0;
        end else begin
            case (m_state)
                0, 3: begin
                    if (rise) begin
                        m_state  = 1;
                        m_reload = 1;
                        wraps    = 0;
                        run_cyc  = 0;
                    end
                end
                1: begin
                    if (c) begin
                        m_state = 2;
                    end else begin
                        if (w) wraps++;
                        run_cyc++;
                        if (run_cyc % TD == TD - 1) begin
                            m_motion = 1;
                            motions++;
                            m_anim = (motions % AD == 0);
                        end
                    end
                end
                2: begin
                    if (f) begin
                        hits++;
                        if (hits == HF) begin
                            m_state    = 3;
                            hits       = 0;
                            enter_over = 1;
                        end
                    end
                end
                default: ;
            endcase
            m_armed = enter_over ? 1'b0 : (m_armed | !b);
            m_prev  = b;
        end
    endtask

    task automatic cyc(input bit r, input bit b, input bit c, input bit w, input bit f);
        reset       = r;
        start_btn   = b;
        collision   = c;
        wrap_event  = w;
        frame_start = f;
        @(posedge clk);
        model_step(r, b, c, w, f);
        @(negedge clk);
        check("m.state",  32'(game_state),     32'(m_state));
        check("m.motion", 32'(motion_tick),    32'(m_motion));
        check("m.anim",   32'(anim_tick),      32'(m_anim));
        check("m.reload", 32'(reload_obs),     32'(m_reload));
        check("m.speed",  32'(obstacle_speed), 32'(exp_speed(wraps)));
        check("m.score",  32'(score_bcd),      32'(to_bcd(wraps)));
        check("m.replay", 32'(show_replay),    32'(m_state == 3));
    endtask

    typedef struct {
        bit          r, b, c, w, f;
        logic [1:0]  st;
        bit          mt, at, rl;
        logic [10:0] sp;
        logic [15:0] sc;
        bit          rp;
    } vec_t;

    vec_t tbl[19];
    int   sp_exp[7];
    int   mcount;
    bit   rb;

    initial begin
        // r b c w f | state mt at rl speed score replay
        tbl[0]  = '{1,0,0,0,0, 2'd0, 0,0,0, 11'd1, 16'h0000, 0};
        tbl[1]  = '{0,0,0,0,0, 2'd0, 0,0,0, 11'd1, 16'h0000, 0};
        tbl[2]  = '{0,1,0,0,0, 2'd1, 0,0,1, 11'd1, 16'h0000, 0};
        tbl[3]  = '{0,1,0,0,0, 2'd1, 0,0,0, 11'd1, 16'h0000, 0};
        tbl[4]  = '{0,1,0,0,0, 2'd1, 0,0,0, 11'd1, 16'h0000, 0};
        tbl[5]  = '{0,1,0,0,0, 2'd1, 1,0,0, 11'd1, 16'h0000, 0};
        tbl[6]  = '{0,1,0,1,0, 2'd1, 0,0,0, 11'd1, 16'h0001, 0};
        tbl[7]  = '{0,1,0,0,0, 2'd1, 0,0,0, 11'd1, 16'h0001, 0};
        tbl[8]  = '{0,1,0,0,0, 2'd1, 0,0,0, 11'd1, 16'h0001, 0};
        tbl[9]  = '{0,1,0,0,0, 2'd1, 1,1,0, 11'd1, 16'h0001, 0};
        tbl[10] = '{0,0,0,0,0, 2'd1, 0,0,0, 11'd1, 16'h0001, 0};
        tbl[11] = '{1,1,0,0,0, 2'd0, 0,0,0, 11'd1, 16'h0000, 0};
        tbl[12] = '{0,1,0,0,0, 2'd0, 0,0,0, 11'd1, 16'h0000, 0};
        tbl[13] = '{0,1,0,0,0, 2'd0, 0,0,0, 11'd1, 16'h0000, 0};
        tbl[14] = '{0,0,0,0,0, 2'd0, 0,0,0, 11'd1, 16'h0000, 0};
        tbl[15] = '{0,1,0,0,0, 2'd1, 0,0,1, 11'd1, 16'h0000, 0};
        tbl[16] = '{0,1,0,1,0, 2'd1, 0,0,0, 11'd1, 16'h0001, 0};
        tbl[17] = '{0,1,0,0,0, 2'd1, 0,0,0, 11'd1, 16'h0001, 0};
        tbl[18] = '{1,1,0,0,0, 2'd0, 0,0,0, 11'd1, 16'h0000, 0};
        sp_exp  = '{1, 1, 2, 2, 2, 3, 3};

        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].r, tbl[i].b, tbl[i].c, tbl[i].w, tbl[i].f);
            check($sformatf("v%0d.state", i),  32'(game_state),     32'(tbl[i].st));
            check($sformatf("v%0d.motion", i), 32'(motion_tick),    32'(tbl[i].mt));
            check($sformatf("v%0d.anim", i),   32'(anim_tick),      32'(tbl[i].at));
            check($sformatf("v%0d.reload", i), 32'(reload_obs),     32'(tbl[i].rl));
            check($sformatf("v%0d.speed", i),  32'(obstacle_speed), 32'(tbl[i].sp));
            check($sformatf("v%0d.score", i),  32'(score_bcd),      32'(tbl[i].sc));
            check($sformatf("v%0d.replay", i), 32'(show_replay),    32'(tbl[i].rp));
        end

        // Speed ramp and saturation over nine wraps.
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check("t3.reload", 32'(reload_obs), 32'd1);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, 1, 0);
            check($sformatf("t3.speed%0d", i + 1), 32'(obstacle_speed), 32'(sp_exp[i]));
        end
        check("t3.score7", 32'(score_bcd), 32'h0007);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        check("t3.score9", 32'(score_bcd), 32'h0009);
        check("t3.speed9", 32'(obstacle_speed), 32'd3);

        // Collision beats a simultaneous wrap; HIT freezes everything.
        cyc(0, 1, 1, 1, 0);
        check("t4.state", 32'(game_state), 32'd2);
        check("t4.score", 32'(score_bcd), 32'h0009);
        mcount = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 0, 1, 0);
            mcount += int'(motion_tick) + int'(anim_tick);
        end
        check("t4.no_ticks", 32'(mcount), 32'd0);
        check("t4.score_hold", 32'(score_bcd), 32'h0009);
        cyc(0, 1, 0, 0, 1);
        check("t4.hit1", 32'(game_state), 32'd2);
        cyc(0, 1, 0, 0, 1);
        check("t4.over", 32'(game_state), 32'd3);
        check("t4.replay", 32'(show_replay), 32'd1);

        // Button held through OVER entry must not restart.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0);
            check("t5.held", 32'(game_state), 32'd3);
        end
        cyc(0, 0, 0, 0, 0);
        check("t5.release", 32'(game_state), 32'd3);
        cyc(0, 1, 0, 0, 0);
        check("t5.state", 32'(game_state), 32'd1);
        check("t5.reload", 32'(reload_obs), 32'd1);
        check("t5.score", 32'(score_bcd), 32'h0000);
        check("t5.speed", 32'(obstacle_speed), 32'd1);
        check("t5.replay", 32'(show_replay), 32'd0);

        // Score saturation at 9999.
        for (int i = 0; i < 9999; i++) begin
            cyc(0, 0, 0, 1, 0);
        end
        check("t5.score9999", 32'(score_bcd), 32'h9999);
        cyc(0, 0, 0, 1, 0);
        check("t5.sat", 32'(score_bcd), 32'h9999);
        check("t5.speed_sat", 32'(obstacle_speed), 32'd3);

        // Randomized play against the model.
        rb = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) rb = ~rb;
            cyc($urandom_range(0, 299) == 0, rb,
                $urandom_range(0, 49) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
